// File: rtl/counter_sequencer.sv
// Run-control sequencer for the ripple counter: owns the slow prescaler timebase and
// issues registered clear / count-enable pulses from start, stop and step requests.
module counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 5000000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic [WIDTH-1:0] cnt_value_i,
    output logic             cnt_en_o,
    output logic             cnt_clr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       state_o
);

    // state | meaning
    // IDLE  | stopped, prescaler held at zero, waiting for start
    // RUN   | prescaler counting, count enable issued on each tick
    // PAUSE | prescaler frozen, step requests advance the counter by one
    // DONE  | counter reached limit, waiting for restart or stop
    localparam int PW = $clog2(DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            start_prev_q, stop_prev_q, step_prev_q;
    logic            armed_q;
    logic            cnt_en_q, cnt_en_d;
    logic            cnt_clr_q, cnt_clr_d;

    logic            start_req, stop_req, step_req;
    logic            tick;
    logic            at_limit;

    // No requests in the first cycle after reset: a level already high then is not an edge.
    assign start_req = armed_q & start_i & ~start_prev_q;
    assign stop_req  = armed_q & stop_i  & ~stop_prev_q;
    assign step_req  = armed_q & step_i  & ~step_prev_q;

    assign tick     = (state_q == S_RUN) && (presc_q == PW'(DIV - 1));
    assign at_limit = (cnt_value_i == limit_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            step_prev_q  <= 1'b0;
            armed_q      <= 1'b0;
            cnt_en_q     <= 1'b0;
            cnt_clr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            start_prev_q <= start_i;
            stop_prev_q  <= stop_i;
            step_prev_q  <= step_i;
            armed_q      <= 1'b1;
            cnt_en_q     <= cnt_en_d;
            cnt_clr_q    <= cnt_clr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                if (start_req) begin
                    state_d   = S_RUN;
                    cnt_clr_d = 1'b1;
                end
            end
            S_RUN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (stop_req) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    if (at_limit) state_d  = S_DONE;
                    else          cnt_en_d = 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop_req) begin
                    state_d = S_IDLE;
                end else if (start_req) begin
                    state_d = S_RUN;
                end else if (step_req) begin
                    if (at_limit) state_d  = S_DONE;
                    else          cnt_en_d = 1'b1;
                end
            end
            S_DONE: begin
                if (stop_req) begin
                    state_d = S_IDLE;
                end else if (start_req) begin
                    state_d   = S_RUN;
                    cnt_clr_d = 1'b1;
                    presc_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt_en_o  = cnt_en_q;
    assign cnt_clr_o = cnt_clr_q;
    assign busy_o    = (state_q == S_RUN);
    assign done_o    = (state_q == S_DONE);
    assign state_o   = state_q;

endmodule
